// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, memory-op tracking FSM
// states and the saturating increment used by the performance counters.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEST_W_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Counters narrower than 32 bits are widened by the caller and truncated back.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Enabled up-counter that sticks at all-ones instead of wrapping (CNT_W <= 32).
module sat_counter
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (en) begin
            count_next = CNT_W'(sat_inc(32'(count_reg), 32'(CNT_MAX)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register: holds the EXE slot while the memory stage is busy,
// raises freeze upstream, and tracks the outstanding op (FSM, watchdog, counters).
module exe_mem_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEST_W  = DEST_W_DEF,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic              mem_ready_in,
    output logic              valid_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DEST_W-1:0] dest_out,
    output logic              freeze_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  mem_op_cnt,
    output logic              timeout_err
);

    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic              valid_reg;
    logic              wb_en_reg;
    logic              mem_r_en_reg;
    logic              mem_w_en_reg;
    logic [DATA_W-1:0] alu_res_reg;
    logic [DATA_W-1:0] val_rm_reg;
    logic [DEST_W-1:0] dest_reg;

    mem_state_e        state_reg;
    mem_state_e        state_next;
    logic [WD_W-1:0]   wd_reg;
    logic [WD_W-1:0]   wd_next;
    logic              err_reg;
    logic              err_next;

    logic              mem_op;
    logic              freeze;
    logic              op_done;

    assign mem_op  = valid_reg & (mem_r_en_reg | mem_w_en_reg);
    assign freeze  = mem_op & ~mem_ready_in;
    assign op_done = mem_op & mem_ready_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg    <= 1'b0;
            wb_en_reg    <= 1'b0;
            mem_r_en_reg <= 1'b0;
            mem_w_en_reg <= 1'b0;
            alu_res_reg  <= '0;
            val_rm_reg   <= '0;
            dest_reg     <= '0;
        end else if (!freeze) begin
            valid_reg    <= valid_in;
            wb_en_reg    <= wb_en_in;
            mem_r_en_reg <= mem_r_en_in;
            mem_w_en_reg <= mem_w_en_in;
            alu_res_reg  <= alu_res_in;
            val_rm_reg   <= val_rm_in;
            dest_reg     <= dest_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            wd_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            wd_reg    <= wd_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (freeze) state_next = WAIT;
            WAIT:    if (mem_ready_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Watchdog only observes; it never releases the freeze on its own.
    always_comb begin
        wd_next  = '0;
        err_next = err_reg;
        if (state_reg == WAIT && !mem_ready_in) begin
            wd_next = wd_reg;
            if (wd_reg != WD_MAX) begin
                wd_next = wd_reg + WD_W'(1);
                if (wd_reg + WD_W'(1) == WD_MAX) begin
                    err_next = 1'b1;
                end
            end
        end
    end

    logic [1:0]       cnt_en;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_en = {op_done, freeze};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_sat_counter (
                .clk   (clk),
                .rst   (rst),
                .en    (cnt_en[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt  = cnt_val[0];
    assign mem_op_cnt = cnt_val[1];

    // Simultaneous load+store is illegal; the store takes priority downstream.
    assign valid_out    = valid_reg;
    assign wb_en_out    = valid_reg & wb_en_reg;
    assign mem_r_en_out = valid_reg & mem_r_en_reg & ~mem_w_en_reg;
    assign mem_w_en_out = valid_reg & mem_w_en_reg;
    assign alu_res_out  = alu_res_reg;
    assign val_rm_out   = val_rm_reg;
    assign dest_out     = dest_reg;
    assign freeze_out   = freeze;
    assign timeout_err  = err_reg;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Bench for exe_mem_reg: stimulus table with hand-derived freeze/counter values,
// a queue of expected captured slots, and hand-written reset/watchdog sequences.
module tb_exe_mem_reg;

    localparam int DW  = 32;
    localparam int RW  = 4;
    localparam int CW  = 16;
    localparam int SCW = 3;
    localparam int TO  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, mem_ready_in;
    logic [DW-1:0] alu_res_in, val_rm_in;
    logic [RW-1:0] dest_in;

    logic          valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, freeze_out, timeout_err;
    logic [DW-1:0] alu_res_out, val_rm_out;
    logic [RW-1:0] dest_out;
    logic [CW-1:0] stall_cnt, mem_op_cnt;

    logic           s_valid, s_wb, s_r, s_w, s_frz, s_err;
    logic [DW-1:0]  s_alu, s_val;
    logic [RW-1:0]  s_dest;
    logic [SCW-1:0] s_stall, s_ops;

    always #5 clk = ~clk;

    exe_mem_reg #(.DATA_W(DW), .DEST_W(RW), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in),
        .val_rm_in(val_rm_in), .dest_in(dest_in), .mem_ready_in(mem_ready_in),
        .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
        .dest_out(dest_out), .freeze_out(freeze_out), .stall_cnt(stall_cnt),
        .mem_op_cnt(mem_op_cnt), .timeout_err(timeout_err)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    exe_mem_reg #(.DATA_W(DW), .DEST_W(RW), .CNT_W(SCW), .TIMEOUT(TO)) dut_small (
        .clk(clk), .rst(rst), .valid_in(valid_in), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in),
        .val_rm_in(val_rm_in), .dest_in(dest_in), .mem_ready_in(mem_ready_in),
        .valid_out(s_valid), .wb_en_out(s_wb), .mem_r_en_out(s_r),
        .mem_w_en_out(s_w), .alu_res_out(s_alu), .val_rm_out(s_val),
        .dest_out(s_dest), .freeze_out(s_frz), .stall_cnt(s_stall),
        .mem_op_cnt(s_ops), .timeout_err(s_err)
    );

    typedef struct {
        logic          v, wb, r, w;
        logic [DW-1:0] alu, val;
        logic [RW-1:0] dest;
        logic          rdy, frz, chk;
        int            stall, ops;
    } vec_t;

    typedef struct {
        logic          v, wb, r, w;
        logic [DW-1:0] alu, val;
        logic [RW-1:0] dest;
    } hold_t;

    int    checks = 0;
    int    errors = 0;
    int    exp_stall, exp_ops;
    hold_t exp_h;
    hold_t sb[$];
    vec_t  vecs[21];

    function automatic vec_t mk(input logic v, wb, r, w, input logic [DW-1:0] alu, val,
                                input logic [RW-1:0] dest, input logic rdy, frz, chk,
                                input int stall, ops);
        vec_t t;
        t.v = v; t.wb = wb; t.r = r; t.w = w; t.alu = alu; t.val = val; t.dest = dest;
        t.rdy = rdy; t.frz = frz; t.chk = chk; t.stall = stall; t.ops = ops;
        return t;
    endfunction

    function automatic int sat_small(input int x);
        return (x > 7) ? 7 : x;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        hold_t h;
        valid_in = t.v; wb_en_in = t.wb; mem_r_en_in = t.r; mem_w_en_in = t.w;
        alu_res_in = t.alu; val_rm_in = t.val; dest_in = t.dest; mem_ready_in = t.rdy;
        #1;
        check("freeze_out", 64'(freeze_out), 64'(t.frz));
        if (t.frz) exp_stall++;
        if (exp_h.v && (exp_h.r || exp_h.w) && t.rdy) exp_ops++;
        if (!t.frz) begin
            h.v = t.v; h.wb = t.wb; h.r = t.r; h.w = t.w;
            h.alu = t.alu; h.val = t.val; h.dest = t.dest;
            sb.push_back(h);
        end
        @(posedge clk);
        #1;
        if (!t.frz) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: queue empty at vector %0d", idx);
            end else begin
                exp_h = sb.pop_front();
            end
        end
        check("ctrl{v,wb,r,w}", 64'({valid_out, wb_en_out, mem_r_en_out, mem_w_en_out}),
              64'({exp_h.v, exp_h.v & exp_h.wb, exp_h.v & exp_h.r & ~exp_h.w, exp_h.v & exp_h.w}));
        check("alu_res_out", 64'(alu_res_out), 64'(exp_h.alu));
        check("val_rm_out", 64'(val_rm_out), 64'(exp_h.val));
        check("dest_out", 64'(dest_out), 64'(exp_h.dest));
        check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        check("mem_op_cnt", 64'(mem_op_cnt), 64'(exp_ops));
        check("small_stall_cnt", 64'(s_stall), 64'(sat_small(exp_stall)));
        check("small_mem_op_cnt", 64'(s_ops), 64'(sat_small(exp_ops)));
        if (t.chk) begin
            check("stall_cnt_plan", 64'(stall_cnt), 64'(t.stall));
            check("mem_op_cnt_plan", 64'(mem_op_cnt), 64'(t.ops));
        end
        $display("vec %0d: rdy=%b frz=%b alu_out=%h dest=%h stall=%0d ops=%0d err=%b",
                 idx, t.rdy, t.frz, alu_res_out, dest_out, stall_cnt, mem_op_cnt, timeout_err);
        @(negedge clk);
    endtask

    initial begin
        // ALU-only stream
        vecs[0]  = mk(1, 1, 0, 0, 32'h10, 32'h0, 4'h1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 32'h20, 32'h0, 4'h2, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 32'h30, 32'h0, 4'h3, 0, 0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 0, 0);
        // load miss with five not-ready cycles; stall inputs must be ignored
        vecs[4]  = mk(1, 1, 1, 0, 32'h400, 32'h0, 4'h5, 1, 0, 0, 0, 0);
        for (int i = 5; i < 10; i++) vecs[i] = mk(1, 0, 0, 1, 32'hDEAD, 32'hBEEF, 4'hE, 0, 1, 0, 0, 0);
        vecs[10] = mk(1, 1, 0, 0, 32'h50, 32'h0, 4'h6, 1, 0, 1, 5, 1);
        // bubble carrying a store request
        vecs[11] = mk(0, 0, 0, 1, 32'h77, 32'h0, 4'h0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 1, 32'h77, 32'h0, 4'h0, 0, 0, 1, 5, 1);
        // store then load back to back, two not-ready cycles each
        vecs[13] = mk(1, 0, 0, 1, 32'h100, 32'hCAFE, 4'h0, 1, 0, 0, 0, 0);
        vecs[14] = mk(1, 1, 1, 0, 32'h200, 32'h0, 4'h7, 0, 1, 0, 0, 0);
        vecs[15] = mk(1, 1, 1, 0, 32'h200, 32'h0, 4'h7, 0, 1, 0, 0, 0);
        vecs[16] = mk(1, 1, 1, 0, 32'h200, 32'h0, 4'h7, 1, 0, 1, 7, 2);
        vecs[17] = mk(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 1, 9, 3);
        vecs[20] = mk(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 1, 9, 3);

        // reset with every input high
        rst = 1'b0;
        valid_in = 1; wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1;
        alu_res_in = '1; val_rm_in = '1; dest_in = '1; mem_ready_in = 1;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, freeze_out}), 64'(0));
        check("rst_data", 64'(alu_res_out | val_rm_out | 32'(dest_out)), 64'(0));
        check("rst_cnt_err", 64'({stall_cnt, mem_op_cnt, timeout_err}), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        // illegal load+store captured: store wins downstream
        check("first_load_ctrl", 64'({valid_out, wb_en_out, mem_r_en_out, mem_w_en_out}), 64'(4'b1101));
        check("first_load_alu", 64'(alu_res_out), 64'(32'hFFFF_FFFF));
        check("first_load_dest", 64'(dest_out), 64'(4'hF));
        check("first_load_freeze", 64'(freeze_out), 64'(0));
        #1 rst = 1'b0;
        #1;
        check("async_rst_ctrl", 64'({valid_out, mem_w_en_out, freeze_out}), 64'(0));
        check("async_rst_alu", 64'(alu_res_out), 64'(0));
        @(negedge clk);
        valid_in = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        alu_res_in = '0; val_rm_in = '0; dest_in = '0; mem_ready_in = 0;
        rst = 1'b1;
        exp_h = '{v: 0, wb: 0, r: 0, w: 0, alu: '0, val: '0, dest: '0};
        exp_stall = 0;
        exp_ops = 0;
        sb.delete();

        for (int i = 0; i < 21; i++) run_vec(i, vecs[i]);

        // watchdog: ready held low on a load
        run_vec(21, mk(1, 1, 1, 0, 32'h900, 32'h0, 4'h8, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 9; i++) begin
            run_vec(21 + i, mk(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0, 0));
            check($sformatf("timeout_err_%0d", i), 64'(timeout_err), 64'(i == 9));
        end
        run_vec(31, mk(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 1, 18, 4));
        check("timeout_err_sticky", 64'(timeout_err), 64'(1));

        // reset in the middle of a wait
        run_vec(32, mk(1, 1, 1, 0, 32'hA00, 32'h0, 4'h9, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) run_vec(33 + i, mk(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0, 0));
        check("pre_rst_freeze", 64'(freeze_out), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("mid_wait_rst_freeze", 64'(freeze_out), 64'(0));
        check("mid_wait_rst_valid", 64'(valid_out), 64'(0));
        check("mid_wait_rst_err", 64'(timeout_err), 64'(0));
        check("mid_wait_rst_cnt", 64'({stall_cnt, mem_op_cnt}), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_freeze", 64'(freeze_out), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_mem_reg.md
Name: exe_mem_reg

Overview:
- Pipeline register between the execute stage and the memory stage.
- Captures the EXE results and control each cycle and holds them stable while the memory stage reports not-ready (cache miss or SRAM write in flight).
- Generates the freeze signal that stalls IF/ID/EXE.
- Tracks the outstanding memory operation with a small FSM, watchdog and performance counters.

Parameters:
- DATA_W, 32, width of ALU result and store value
- DEST_W, 4, register-file destination index width
- CNT_W, 16, width of performance counters
- TIMEOUT, 1023, max cycles a memory op may stay not-ready before the error flag is set

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  EXE slot holds a real instruction (0 = bubble)
- wb_en_in  in  1  write-back enable from EXE
- mem_r_en_in  in  1  load request from EXE
- mem_w_en_in  in  1  store request from EXE
- alu_res_in  in  DATA_W  ALU result / effective address
- val_rm_in  in  DATA_W  store data
- dest_in  in  DEST_W  destination register
- mem_ready_in  in  1  ready from memory stage; 1 = current op completes this cycle
- valid_out  out  1  held slot valid
- wb_en_out  out  1  to memory stage, gated by valid_out
- mem_r_en_out  out  1  to memory stage, gated by valid_out
- mem_w_en_out  out  1  to memory stage, gated by valid_out
- alu_res_out  out  DATA_W  held address/result
- val_rm_out  out  DATA_W  held store data
- dest_out  out  DEST_W  held destination
- freeze_out  out  1  stall request to upstream stages and to the PC
- stall_cnt  out  CNT_W  total cycles spent frozen, saturating
- mem_op_cnt  out  CNT_W  completed loads and stores, saturating
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM=IDLE, watchdog counter 0.
- mem_op = valid_out & (mem_r_en_out | mem_w_en_out).
- freeze_out = mem_op & ~mem_ready_in. This is combinational, so the stall takes effect in the same cycle as the not-ready.
- Register update: on each rising edge with freeze_out=0, load all *_in fields. valid_out <= valid_in.
- With freeze_out=1, all held fields keep their value. Inputs are ignored; upstream is frozen too.
- Control outputs are ANDed with valid_out. A bubble never issues a memory request or a write-back.
- mem_r_en_in and mem_w_en_in both 1: illegal. Register captures both; mem_w wins downstream. Counted once.
- Latency: 1 cycle EXE→MEM when not frozen.
- FSM states and transitions:
  - IDLE -> WAIT when mem_op & ~mem_ready_in.
  - IDLE stays IDLE when there is no mem_op, or mem_ready_in=1 (1-cycle hit; counted as completed).
  - WAIT stays WAIT while mem_ready_in=0; watchdog increments.
  - WAIT -> IDLE when mem_ready_in=1: op completes, register advances on the same edge, watchdog cleared.
- Watchdog: in WAIT, when the count reaches TIMEOUT, timeout_err <= 1. It is sticky until reset. Freeze is not released; the error is observational only.
- stall_cnt: +1 on every edge with freeze_out=1. Saturates at all-ones, no wrap.
- mem_op_cnt: +1 on every edge where mem_op & mem_ready_in. Saturates.
- Back-to-back memory ops: the second op appears at the outputs the cycle after the first completes. No dead cycle is inserted.
- mem_ready_in glitching high while no mem_op: ignored.
- Reset mid-WAIT: immediate return to IDLE and freeze_out=0. The held op is discarded.

Decomposition:
- Shared package cpu_pkg holds:
  - the FSM state typedef (IDLE, WAIT)
  - the DATA_W and DEST_W defaults
  - a saturating-increment function used by both counters
- One natural sub-module, sat_counter (CNT_W-wide, enable, saturating), instantiated twice.
- The watchdog and FSM stay inline.

Test Plan:
- Reset: hold rst=0 with all inputs at 1 -> every output 0, freeze_out=0; release -> first edge loads inputs.
- ALU-only stream: valid_in=1, wb_en_in=1, alu_res_in=0x10, 0x20, 0x30 on consecutive cycles -> outputs follow 1 cycle later; freeze_out stays 0; stall_cnt=0, mem_op_cnt=0.
- Load miss: mem_r_en_in=1, alu_res_in=0x400, then mem_ready_in=0 for 5 cycles, then 1:
  - freeze_out high exactly 5 cycles; alu_res_out holds 0x400 throughout;
  - changed inputs during the stall are ignored;
  - stall_cnt=5, mem_op_cnt=1.
- Bubble gating: valid_in=0 with mem_w_en_in=1 -> mem_w_en_out=0, freeze_out=0 even with mem_ready_in=0.
- Back-to-back store then load, each with 2 ready-low cycles -> load address at outputs the cycle after the store completes; stall_cnt=4, mem_op_cnt=2.
- Watchdog: TIMEOUT=8, mem_ready_in held 0 -> timeout_err rises after 8 WAIT cycles and stays 1 after ready returns; asserting rst mid-WAIT clears it and drops freeze_out immediately.
